// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter
// Purpose  : Shares one external 32-bit left barrel shifter between two
//            requesters: arbitrate, drive operands, capture result, pulse done.
//            Define SHIFT_ARB_RR_EN for round-robin ties (default: req0 wins).
// Revision : 1.0 - initial release
// ============================================================================
module shift_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] a0,
    input  logic [4:0]  amt0,
    input  logic        fill0,
    input  logic        req1,
    input  logic [31:0] a1,
    input  logic [4:0]  amt1,
    input  logic        fill1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] res,
    output logic        busy,
    output logic [31:0] sh_a,
    output logic [31:0] sh_b,
    output logic        sh_s,
    input  logic [31:0] sh_r
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_resp  = 2'd2;

    logic [1:0]  state_q,   state_d;
    logic        gnt_q,     gnt_d;
    logic [31:0] sh_a_q,    sh_a_d;
    logic [4:0]  sh_amt_q,  sh_amt_d;
    logic        sh_s_q,    sh_s_d;
    logic [31:0] res_q,     res_d;
    logic        done0_q,   done0_d;
    logic        done1_q,   done1_d;
    logic        busy_q,    busy_d;
    logic        w_win_id;

`ifdef SHIFT_ARB_RR_EN
    logic        rr_q,      rr_d;
    logic        w_tie;

    // rr points at the requester that loses nothing on the next tie
    always_comb begin
        w_tie    = req0 & req1;
        w_win_id = w_tie ? rr_q : req1;
    end
`else
    always_comb begin
        w_win_id = req1 & ~req0;
    end
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sh_a_d   = sh_a_q;
        sh_amt_d = sh_amt_q;
        sh_s_d   = sh_s_q;
        res_d    = res_q;
        busy_d   = busy_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
`ifdef SHIFT_ARB_RR_EN
        rr_d     = rr_q;
`endif
        case (state_q)
            c_st_idle: begin
                if (req0 | req1) begin
                    state_d  = c_st_shift;
                    busy_d   = 1'b1;
                    gnt_d    = w_win_id;
                    sh_a_d   = w_win_id ? a1    : a0;
                    sh_amt_d = w_win_id ? amt1  : amt0;
                    sh_s_d   = w_win_id ? fill1 : fill0;
`ifdef SHIFT_ARB_RR_EN
                    rr_d     = ~w_win_id;
`endif
                end
            end
            c_st_shift: begin
                // Shifter has had the whole SHIFT cycle to settle
                state_d = c_st_resp;
                res_d   = sh_r;
                done0_d = ~gnt_q;
                done1_d = gnt_q;
            end
            c_st_resp: begin
                state_d = c_st_idle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = c_st_idle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= c_st_idle;
            gnt_q    <= 1'b0;
            sh_a_q   <= 32'd0;
            sh_amt_q <= 5'd0;
            sh_s_q   <= 1'b0;
            res_q    <= 32'd0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SHIFT_ARB_RR_EN
            rr_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            sh_a_q   <= sh_a_d;
            sh_amt_q <= sh_amt_d;
            sh_s_q   <= sh_s_d;
            res_q    <= res_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
`ifdef SHIFT_ARB_RR_EN
            rr_q     <= rr_d;
`endif
        end
    end

    assign done0 = done0_q;
    assign done1 = done1_q;
    assign res   = res_q;
    assign busy  = busy_q;
    assign sh_a  = sh_a_q;
    assign sh_b  = {27'd0, sh_amt_q};
    assign sh_s  = sh_s_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// Testbench for shift_arbiter: directed requests, scoreboard of expected
// (id, result) pairs checked by an independent done monitor.
module tb_shift_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, fill0, req1, fill1;
    logic [31:0] a0, a1;
    logic [4:0]  amt0, amt1;
    logic        done0, done1, busy, sh_s;
    logic [31:0] res, sh_a, sh_b, sh_r;

    int tests;
    int fails;

    typedef struct packed {
        logic        id;
        logic [31:0] r;
    } exp_t;
    exp_t sb[$];

    shift_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .a0    (a0),
        .amt0  (amt0),
        .fill0 (fill0),
        .req1  (req1),
        .a1    (a1),
        .amt1  (amt1),
        .fill1 (fill1),
        .done0 (done0),
        .done1 (done1),
        .res   (res),
        .busy  (busy),
        .sh_a  (sh_a),
        .sh_b  (sh_b),
        .sh_s  (sh_s),
        .sh_r  (sh_r)
    );

    // External shifter: left shift, fill bit into vacated low positions
    always_comb begin
        if (sh_s)
            sh_r = (sh_a << sh_b[4:0]) | ~(32'hFFFF_FFFF << sh_b[4:0]);
        else
            sh_r = sh_a << sh_b[4:0];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (done0 || done1) begin
            exp_t e;
            tests++;
            if (done0 && done1) begin
                fails++;
                $display("FAIL done_excl: got done0=%0b done1=%0b expected one-hot", done0, done1);
            end else if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got done0=%0b done1=%0b res=%h expected no done", done0, done1, res);
            end else begin
                e = sb.pop_front();
                if (done1 !== e.id || res !== e.r) begin
                    fails++;
                    $display("FAIL sb_result: got id=%0d res=%h expected id=%0d res=%h", done1, res, e.id, e.r);
                end
            end
        end
    end

    task automatic run_op(input logic id, input logic [31:0] a, input logic [4:0] amt,
                          input logic fill, input logic [31:0] exp, input logic corrupt);
        int n;
        logic got;
        sb.push_back({id, exp});
        if (id) begin req1 = 1'b1; a1 = a; amt1 = amt; fill1 = fill; end
        else    begin req0 = 1'b1; a0 = a; amt0 = amt; fill0 = fill; end
        @(posedge clk); #1;
        check("busy_shift", {31'd0, busy}, 32'd1);
        check("sh_a_shift", sh_a, a);
        check("sh_b_shift", sh_b, {27'd0, amt});
        check("sh_s_shift", {31'd0, sh_s}, {31'd0, fill});
        if (corrupt) begin a0 = 32'hFFFF_FFFF; a1 = 32'hFFFF_FFFF; end
        got = 1'b0;
        n = 0;
        while (!got && n < 8) begin
            @(posedge clk); #1;
            n++;
            if (id ? done1 : done0) got = 1'b1;
        end
        check("done_latency", n, 1);
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk); #1;
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("res_hold", res, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1;
        req0 = 0; a0 = 0; amt0 = 0; fill0 = 0;
        req1 = 0; a1 = 0; amt1 = 0; fill1 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done0", {31'd0, done0}, 32'd0);
        check("rst_done1", {31'd0, done1}, 32'd0);
        check("rst_res",   res,  32'd0);
        check("rst_sh_a",  sh_a, 32'd0);
        check("rst_sh_b",  sh_b, 32'd0);
        check("rst_sh_s",  {31'd0, sh_s}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 32'h0000_0001, 5'd4,  1'b0, 32'h0000_0010, 1'b0);
        run_op(1'b1, 32'h8000_00FF, 5'd8,  1'b1, 32'h0000_FFFF, 1'b0);
        run_op(1'b1, 32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 1'b0);
        run_op(1'b0, 32'h0000_00F0, 5'd4,  1'b0, 32'h0000_0F00, 1'b1);
        run_op(1'b0, 32'h0000_0003, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0);

        // Reset during SHIFT discards the operation
        req0 = 1'b1; a0 = 32'h3; amt0 = 5'd1; fill0 = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; req0 = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_outs", {res | sh_a | sh_b}, 32'd0);
        check("mid_rst_bits", {28'd0, busy, done0, done1, sh_s}, 32'd0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        run_op(1'b0, 32'h0000_0003, 5'd1, 1'b0, 32'h0000_0006, 1'b0);

        // req1 arrives while requester 0 is being served
        sb.push_back({1'b0, 32'h0000_0014});
        sb.push_back({1'b1, 32'h8000_0000});
        req0 = 1'b1; a0 = 32'h5; amt0 = 5'd2; fill0 = 1'b0;
        @(posedge clk); #1;
        req1 = 1'b1; a1 = 32'h1; amt1 = 5'd31; fill1 = 1'b0;
        @(posedge clk); #1;
        check("late_done0", {31'd0, done0}, 32'd1);
        req0 = 1'b0;
        @(posedge clk); #1;
        check("late_idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("late_grant_busy", {31'd0, busy}, 32'd1);
        check("late_grant_sh_a", sh_a, 32'h1);
        @(posedge clk); #1;
        check("late_done1", {31'd0, done1}, 32'd1);
        req1 = 1'b0;
        @(posedge clk); #1;

        // Both held continuously from a fresh reset
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
`ifdef SHIFT_ARB_RR_EN
        sb.push_back({1'b0, 32'h2}); sb.push_back({1'b1, 32'h4});
        sb.push_back({1'b0, 32'h2}); sb.push_back({1'b1, 32'h4});
`else
        repeat (4) sb.push_back({1'b0, 32'h2});
`endif
        req0 = 1'b1; a0 = 32'h1; amt0 = 5'd1; fill0 = 1'b0;
        req1 = 1'b1; a1 = 32'h1; amt1 = 5'd2; fill1 = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            @(posedge clk); #1;
            check("tie_done_spacing", {31'd0, done0 | done1}, {31'd0, (i % 3) == 1});
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
